fact_accel_mmio: RTL and testbench

// - Memory-mapped factorial accelerator on the mips_top data bus, beside data memory and GPIO.
// - The CPU writes n and a GO strobe, polls STATUS, then reads RESULT = n!.
// - The system address decoder drives `we` and `a`; `rd` feeds the read-data mux back to the CPU.
// - Iterative: one multiply per clock, so the CPU is never stalled.

---
 rtl/fact_accel_mmio_pkg.sv | 17 +
 rtl/fact_dp.sv | 40 ++++
 rtl/fact_accel_mmio.sv | 120 ++++++++++++
 tb/tb_fact_accel_mmio.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fact_accel_mmio_pkg.sv
// Shared definitions for the factorial accelerator: register offsets
// on the data bus and the controller state encoding.
package fact_accel_mmio_pkg;

   // Register offsets (word address bits [3:2])
   localparam logic [1:0] FACT_A_N      = 2'd0;
   localparam logic [1:0] FACT_A_GO     = 2'd1;
   localparam logic [1:0] FACT_A_STATUS = 2'd2;
   localparam logic [1:0] FACT_A_RESULT = 2'd3;

   // Controller states
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fact_state_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: running product and down-counter with one
// DATA_WIDTH x N_WIDTH unsigned multiply per step.
module fact_dp #(
   parameter int N_WIDTH    = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [N_WIDTH-1:0]    n,
   output logic [DATA_WIDTH-1:0] acc,
   output logic                  cnt_gt1
);

   logic [N_WIDTH-1:0]    cnt;
   logic [DATA_WIDTH-1:0] cnt_ext;
   logic [DATA_WIDTH-1:0] product;

   // Zero-extend the counter so the product keeps the accumulator width;
   // the upper half of the full product is dropped (truncation).
   assign cnt_ext = {{(DATA_WIDTH-N_WIDTH){1'b0}}, cnt};
   assign product = acc * cnt_ext;
   assign cnt_gt1 = (cnt > N_WIDTH'(1));

   // Load seeds acc=1, cnt=n; each step folds cnt into the product and counts down.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= DATA_WIDTH'(1);
         cnt <= n;
      end else if (step) begin
         acc <= product;
         cnt <= cnt - N_WIDTH'(1);
      end
   end

endmodule

// File: rtl/fact_accel_mmio.sv
// Memory-mapped factorial accelerator. The CPU writes n, strobes GO,
// polls STATUS and reads RESULT = n!. Register file and controller live
// here; the multiply/count datapath is in fact_dp.
module fact_accel_mmio
   import fact_accel_mmio_pkg::*;
#(
   parameter int N_WIDTH    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int N_MAX      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [1:0]            a,
   input  logic [DATA_WIDTH-1:0] wd,
   output logic [DATA_WIDTH-1:0] rd,
   output logic                  done
);

   localparam logic [N_WIDTH-1:0] N_LIMIT = N_WIDTH'(N_MAX);

   fact_state_t           state;
   fact_state_t           state_next;
   logic [N_WIDTH-1:0]    n_reg;
   logic [DATA_WIDTH-1:0] result;
   logic [DATA_WIDTH-1:0] acc;
   logic                  err;
   logic                  cnt_gt1;
   logic                  busy;
   logic                  go_req;
   logic                  load;
   logic                  step;
   logic                  finish;
   logic                  unused_wd;

   // Only the low N_WIDTH bits of write data are ever stored.
   assign unused_wd = ^wd[DATA_WIDTH-1:N_WIDTH];

   assign busy   = (state == BUSY);
   assign go_req = we && (a == FACT_A_GO) && wd[0];

   fact_dp #(
      .N_WIDTH   (N_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_dp (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .n      (n_reg),
      .acc    (acc),
      .cnt_gt1(cnt_gt1)
   );

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and datapath controls; GO is only honoured in IDLE.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (go_req) begin
               load       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (!err && cnt_gt1) begin
               step = 1'b1;
            end else begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // N register: writable at any time; a running job keeps its latched count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        n_reg <= '0;
      else if (we && a == FACT_A_N)   n_reg <= wd[N_WIDTH-1:0];
   end

   // Status and result: cleared on an accepted GO, published when the job ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else if (load) begin
         result <= '0;
         done   <= 1'b0;
         err    <= (n_reg > N_LIMIT);
      end else if (finish) begin
         result <= err ? '0 : acc;
         done   <= 1'b1;
      end
   end

   // Read-data mux, combinational from the register select.
   always_comb begin
      rd = '0;
      case (a)
         FACT_A_N:      rd = {{(DATA_WIDTH-N_WIDTH){1'b0}}, n_reg};
         FACT_A_GO:     rd = {{(DATA_WIDTH-1){1'b0}}, busy};
         FACT_A_STATUS: rd = {{(DATA_WIDTH-2){1'b0}}, err, done};
         FACT_A_RESULT: rd = result;
         default:       rd = '0;
      endcase
   end

endmodule

// File: tb/tb_fact_accel_mmio.sv
// Directed bench for fact_accel_mmio: register map, latency, results,
// error path and mid-run robustness.
module tb_fact_accel_mmio;

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        done;

   int checks;
   int failures;

   fact_accel_mmio dut (
      .clk (clk),
      .rst (rst),
      .we  (we),
      .a   (a),
      .wd  (wd),
      .rd  (rd),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus write: drive at the falling edge, commit on the rising edge.
   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clk);
      we = 1'b1; a = addr; wd = data;
      @(posedge clk);
      #1;
      we = 1'b0; wd = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
      a = addr;
      #1;
      data = rd;
   endtask

   // Rising edges from the GO edge until done is seen; -1 when it never comes.
   task automatic wait_done(output int edges);
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic run_fact(input logic [31:0] n, output int edges);
      bus_write(2'd0, n);
      bus_write(2'd1, 32'd1);
      wait_done(edges);
   endtask

   task automatic test_reset;
      logic [31:0] v;
      rst = 1'b1; we = 1'b0; a = 2'd0; wd = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         bus_read(2'(i), v);
         checks++;
         if (v !== 32'd0) begin
            failures++;
            $display("FAIL reset_rd a=%0d got=%h exp=%h", i, v, 32'd0);
         end
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b exp=0", done);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fact5;
      int e;
      logic [31:0] v;
      run_fact(32'd5, e);
      checks++;
      if (e != 5) begin failures++; $display("FAIL f5_latency got=%0d exp=5", e); end
      bus_read(2'd3, v);
      checks++;
      if (v !== 32'd120) begin failures++; $display("FAIL f5_result got=%h exp=%h", v, 32'd120); end
      bus_read(2'd2, v);
      checks++;
      if (v !== 32'd1) begin failures++; $display("FAIL f5_status got=%h exp=%h", v, 32'd1); end
      bus_read(2'd1, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL f5_busy_idle got=%h exp=0", v); end
   endtask

   task automatic test_small;
      int e;
      logic [31:0] v;
      for (int n = 0; n < 2; n++) begin
         run_fact(32'(n), e);
         checks++;
         if (e != 1) begin failures++; $display("FAIL small_latency n=%0d got=%0d exp=1", n, e); end
         bus_read(2'd3, v);
         checks++;
         if (v !== 32'd1) begin failures++; $display("FAIL small_result n=%0d got=%h exp=1", n, v); end
      end
   endtask

   task automatic test_fact12;
      int e;
      logic [31:0] v;
      run_fact(32'd12, e);
      checks++;
      if (e != 12) begin failures++; $display("FAIL f12_latency got=%0d exp=12", e); end
      bus_read(2'd3, v);
      checks++;
      if (v !== 32'h1C8C_FC00) begin failures++; $display("FAIL f12_result got=%h exp=1c8cfc00", v); end
      bus_read(2'd2, v);
      checks++;
      if (v !== 32'd1) begin failures++; $display("FAIL f12_status got=%h exp=1", v); end
   endtask

   task automatic test_err;
      int e;
      logic [31:0] v;
      run_fact(32'd13, e);
      checks++;
      if (e != 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", e); end
      bus_read(2'd3, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL err_result got=%h exp=0", v); end
      bus_read(2'd2, v);
      checks++;
      if (v !== 32'd3) begin failures++; $display("FAIL err_status got=%h exp=3", v); end
      bus_read(2'd0, v);
      checks++;
      if (v !== 32'd13) begin failures++; $display("FAIL err_nreg got=%h exp=d", v); end
   endtask

   task automatic test_ignored_writes;
      int e;
      logic [31:0] v;
      run_fact(32'd4, e);
      // GO with bit0 clear, and writes to STATUS/RESULT, change nothing
      bus_write(2'd1, 32'hFFFF_FFFE);
      bus_write(2'd2, 32'hFFFF_FFFF);
      bus_write(2'd3, 32'h1234_5678);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL nogo_done got=%b exp=1", done); end
      bus_read(2'd3, v);
      checks++;
      if (v !== 32'd24) begin failures++; $display("FAIL nogo_result got=%h exp=%h", v, 32'd24); end
      bus_read(2'd1, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL nogo_busy got=%h exp=0", v); end
   endtask

   task automatic test_back_to_back;
      int e;
      logic [31:0] v;
      bus_write(2'd0, 32'd6);
      bus_write(2'd1, 32'd1);
      bus_read(2'd1, v);
      checks++;
      if (v !== 32'd1) begin failures++; $display("FAIL b2b_busy got=%h exp=1", v); end
      bus_write(2'd0, 32'd3);
      bus_write(2'd1, 32'd1);
      wait_done(e);
      checks++;
      if (e != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", e); end
      bus_read(2'd3, v);
      checks++;
      if (v !== 32'd720) begin failures++; $display("FAIL b2b_result6 got=%h exp=%h", v, 32'd720); end
      bus_read(2'd0, v);
      checks++;
      if (v !== 32'd3) begin failures++; $display("FAIL b2b_nreg got=%h exp=3", v); end
      bus_write(2'd1, 32'd1);
      wait_done(e);
      checks++;
      if (e != 3) begin failures++; $display("FAIL b2b_latency3 got=%0d exp=3", e); end
      bus_read(2'd3, v);
      checks++;
      if (v !== 32'd6) begin failures++; $display("FAIL b2b_result3 got=%h exp=6", v); end
   endtask

   task automatic test_reset_midrun;
      logic [31:0] v;
      bus_write(2'd0, 32'd6);
      bus_write(2'd1, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         bus_read(2'(i), v);
         checks++;
         if (v !== 32'd0) begin
            failures++;
            $display("FAIL midrst_rd a=%0d got=%h exp=0", i, v);
         end
      end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL midrst_stays_idle got=%b exp=0", done); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset;
      test_fact5;
      test_small;
      test_fact12;
      test_err;
      test_ignored_writes;
      test_back_to_back;
      test_reset_midrun;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
